soft_decode_batch_ctrl: RTL
===========================

# soft_decode_batch_ctrl

Batch controller that drives one `soft_decoder` instance over a sequence of received strands and reduces the results. It accepts strands through a valid/ready stream, pulses the decoder's `start` once per strand, and waits for `done`. Each per-position `likelyhood` vector is added into saturating accumulators. After the batch it scans for the most likely position and presents the accumulated vector plus the argmax index on an output handshake.

## Interface
- `DATA_WIDTH`, 11, strand width; matches the decoder.
- `n`, 5, number of likelihood positions (indexed 1..n).
- `ACC_WIDTH`, 40, signed accumulator width; must be at least 32.
- `MAX_BATCH`, 16, maximum strands per batch.
- `TIMEOUT_CYCLES`, 1024, watchdog limit; used only when the timeout feature is compiled in.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  one-cycle request to begin a batch; honoured only in IDLE.
- `batch_len`  in  $clog2(MAX_BATCH+1)  strands in the batch; sampled with `cfg_start`.
- `in_valid`  in  1  strand available.
- `in_ready`  out  1  controller accepts a strand.
- `in_strand`  in  DATA_WIDTH  strand data.
- `dec_start`  out  1  decoder start pulse.
- `dec_N`  out  32  decoder `N` input; equals the latched `batch_len`, zero-extended.
- `dec_strand`  out  DATA_WIDTH  decoder strand input.
- `dec_likelyhood[n:1]`  in  32 signed each  decoder result.
- `dec_done`  in  1  decoder completion.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `acc[n:1]`  out  ACC_WIDTH signed each  accumulated likelihoods.
- `best_idx`  out  $clog2(n+1)  argmax position, 1..n.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky error flag; present only with the timeout feature.

## Operation
- States: IDLE, FETCH, WAIT, ACCUM, SCAN, OUT.
- IDLE:
  - On `cfg_start`: latch `batch_len`, clear `acc`, clear the strand counter `cnt`.
  - If `batch_len==0`, go to SCAN; otherwise go to FETCH.
- FETCH:
  - `in_ready=1`.
  - On `in_valid&&in_ready`: register `in_strand` into `dec_strand`, set `dec_start`, go to WAIT.
- WAIT:
  - `dec_start` is high only on the first WAIT cycle.
  - `dec_done` is ignored while `dec_start` is high.
  - When `dec_done` is seen afterwards, capture `dec_likelyhood` and go to ACCUM.
- ACCUM (1 cycle):
  - `acc[i] <= sat(acc[i] + sext(captured[i]))` for every i.
  - Saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Increment `cnt`. Go to SCAN if `cnt+1==batch_len`, else to FETCH.
- SCAN (exactly n cycles, i = 1..n):
  - Running max, updated only on a strictly greater value, so ties resolve to the lowest index.
  - Then go to OUT.
- OUT:
  - `out_valid=1`; `acc` and `best_idx` are held stable.
  - On `out_ready`, go to IDLE.
- `cfg_start` outside IDLE is ignored.
- `dec_strand` is held stable from the handshake until the next handshake.
- `dec_done` is ignored in every state except WAIT.
- Reset, including mid-batch:
  - Return to IDLE.
  - All outputs are 0, except `best_idx=1`.
  - Any in-flight decoder result is discarded, because `dec_done` is ignored in IDLE.

## Timing
- Handshake on edge k: `dec_start=1` during cycle k+1; deasserted at edge k+2.
- `dec_done` seen at edge d: ACCUM in cycle d+1; FETCH or SCAN from d+2.
- `in_ready` can reassert at the earliest 2 cycles after `dec_done` is seen.
- Last ACCUM to `out_valid`: n+1 cycles (n SCAN cycles, then OUT).
- `batch_len==0`: `cfg_start` at edge k gives `out_valid` in cycle k+n+1, with all-zero `acc` and `best_idx=1`.
- Total batch latency = Σ(decoder latency + 3) + n + 1 cycles, plus input stall cycles.

## Configuration
- `SOFT_DEC_TIMEOUT_EN` defined:
  - A watchdog counts WAIT cycles.
  - Reaching `TIMEOUT_CYCLES` without `dec_done` sets `timeout_err`.
  - The controller then aborts directly to OUT with the current `acc`; no SCAN is run and `best_idx=1`.
  - `timeout_err` is cleared by `rst` or by the next honoured `cfg_start`.
- `SOFT_DEC_TIMEOUT_EN` undefined:
  - No watchdog; WAIT lasts indefinitely.
  - The `timeout_err` port is absent.

## Test plan
- **Single strand.** `batch_len=1`, strand 11'b011, decoder model returns {10,-3,7,10,2} → `dec_start` is one cycle wide and `dec_N=1`; `acc={10,-3,7,10,2}`, `best_idx=1` (tie resolves to the lower index).
- **Batch accumulation.** `batch_len=3`, each result {1,2,3,4,5}·k for k=1,2,3 → `acc={6,12,18,24,30}`, `best_idx=5`, exactly 3 `dec_start` pulses.
- **Saturation.** `ACC_WIDTH=33`, 4 results of 2^31-1 at position 2 → `acc[2]=2^32-1` (saturated), no wrap.
- **Backpressure and spurious done.**
  - `in_valid` low for 5 cycles in FETCH → `dec_start` waits for the handshake.
  - `dec_done` asserted during IDLE → ignored.
  - `out_ready` low for 4 cycles → `out_valid` and `acc` stay stable.
- **Reset mid-WAIT.** `rst` pulsed in WAIT of strand 2 → next cycle IDLE, `busy=0`, `acc=0`; a later `dec_done` produces no accumulation.
- **Timeout (with `SOFT_DEC_TIMEOUT_EN`).** `TIMEOUT_CYCLES=8`, decoder never asserts `dec_done` → `timeout_err=1` and `out_valid=1` once the 8-cycle watchdog expires; the next `cfg_start` clears `timeout_err`.

Source files
------------

// File: rtl/soft_decode_batch_ctrl.sv
// Batch controller: feeds strands to one soft_decoder, accumulates saturated likelihoods, then scans for the argmax.
// Optional watchdog on the decoder wait is compiled in with `define SOFT_DEC_TIMEOUT_EN.
module soft_decode_batch_ctrl #(
    parameter int DATA_WIDTH     = 11,
    parameter int n              = 5,
    parameter int ACC_WIDTH      = 40,
    parameter int MAX_BATCH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LW = $clog2(MAX_BATCH + 1),
    localparam int IW = $clog2(n + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [LW-1:0]               batch_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_strand,
    output logic                        dec_start,
    output logic [31:0]                 dec_N,
    output logic [DATA_WIDTH-1:0]       dec_strand,
    input  logic signed [31:0]          dec_likelyhood [n:1],
    input  logic                        dec_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] acc [n:1],
    output logic [IW-1:0]               best_idx,
    output logic                        busy,
    output logic [2:0]                  dbg_state
`ifdef SOFT_DEC_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and the producer holds its data until the transfer.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_SCAN  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic [LW-1:0]                 len_q;
    logic [LW-1:0]                 cnt_q;
    logic [IW-1:0]                 scan_i_q;
    logic signed [ACC_WIDTH-1:0]   max_q;
    logic signed [31:0]            cap_q   [n:1];
    logic signed [ACC_WIDTH:0]     wide    [n:1];
    logic signed [ACC_WIDTH-1:0]   sat_sum [n:1];
    logic                          done_ok;

    // dec_done in the pulse cycle belongs to the previous decode and is not trusted.
    assign done_ok   = dec_done && !dec_start;
    assign in_ready  = (state_q == S_FETCH);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign dec_N     = {{(32 - LW){1'b0}}, len_q};

`ifdef SOFT_DEC_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    logic          wd_expired;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
`ifdef SOFT_DEC_TIMEOUT_EN
        wd_expired = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_start) state_d = (batch_len == '0) ? S_SCAN : S_FETCH;
            end
            S_FETCH: begin
                if (in_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_ok) begin
                    state_d = S_ACCUM;
                end
`ifdef SOFT_DEC_TIMEOUT_EN
                else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_OUT;
                    wd_expired = 1'b1;
                end
`endif
            end
            S_ACCUM: begin
                state_d = (cnt_q + LW'(1) == len_q) ? S_SCAN : S_FETCH;
            end
            S_SCAN: begin
                if (scan_i_q == IW'(n)) state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sum one bit wider than the accumulator so overflow shows as a sign disagreement.
    always_comb begin
        for (int i = 1; i <= n; i++) begin
            wide[i] = $signed({acc[i][ACC_WIDTH-1], acc[i]})
                    + $signed({{(ACC_WIDTH + 1 - 32){cap_q[i][31]}}, cap_q[i]});
            sat_sum[i] = wide[i][ACC_WIDTH-1:0];
            if (wide[i][ACC_WIDTH] != wide[i][ACC_WIDTH-1]) begin
                sat_sum[i] = wide[i][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                                : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            scan_i_q   <= '0;
            max_q      <= '0;
            dec_start  <= 1'b0;
            dec_strand <= '0;
            best_idx   <= IW'(1);
            for (int i = 1; i <= n; i++) begin
                acc[i]   <= '0;
                cap_q[i] <= '0;
            end
        end else begin
            dec_start <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        len_q    <= batch_len;
                        cnt_q    <= '0;
                        scan_i_q <= IW'(1);
                        for (int i = 1; i <= n; i++) acc[i] <= '0;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        dec_strand <= in_strand;
                        dec_start  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done_ok) cap_q <= dec_likelyhood;
`ifdef SOFT_DEC_TIMEOUT_EN
                    if (wd_expired) best_idx <= IW'(1);
`endif
                end
                S_ACCUM: begin
                    acc      <= sat_sum;
                    cnt_q    <= cnt_q + LW'(1);
                    scan_i_q <= IW'(1);
                end
                S_SCAN: begin
                    // First position seeds the max; later ones replace it only when strictly larger.
                    if (scan_i_q == IW'(1) || acc[scan_i_q] > max_q) begin
                        max_q    <= acc[scan_i_q];
                        best_idx <= scan_i_q;
                    end
                    scan_i_q <= scan_i_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SOFT_DEC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_q <= (state_q == S_WAIT) ? wd_q + WW'(1) : '0;
            if (state_q == S_IDLE && cfg_start) timeout_err <= 1'b0;
            if (wd_expired)                     timeout_err <= 1'b1;
        end
    end
`endif

endmodule
